// File: rtl/i2c_target_pkg.sv
// Shared state encoding, bus levels and helpers for the I2C register target.
package i2c_target_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_IGNORE
   } i2c_target_state_e;

   localparam logic I2C_ACK      = 1'b0;
   localparam logic I2C_NACK     = 1'b1;
   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/i2c_target_regs_if.sv
// Bus side (open-drain SCL/SDA levels) and host side (peek port, write observation) of the target.
interface i2c_target_regs_if #(
   parameter int AW = 4
);
   logic          i2c_scl_i;
   logic          i2c_sda_i;
   logic          i2c_sda_o;
   logic          i2c_sda_t;
   logic [AW-1:0] reg_rd_addr;
   logic [7:0]    reg_rd_data;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy;

   modport slave (
      input  i2c_scl_i, i2c_sda_i, reg_rd_addr,
      output i2c_sda_o, i2c_sda_t, reg_rd_data, wr_valid, wr_addr, wr_data, busy
   );

   modport master (
      output i2c_scl_i, i2c_sda_i, reg_rd_addr,
      input  i2c_sda_o, i2c_sda_t, reg_rd_data, wr_valid, wr_addr, wr_data, busy
   );
endinterface

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-FF sync, optional 3-sample majority filter (I2C_TARGET_GLITCH_FILTER_EN),
// then a history register giving SCL edges and START/STOP; events valid 3 clk (5 filtered) after the pins.
module i2c_line_cond (
   input  logic clk,
   input  logic rst,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);
   logic [1:0] r_scl_sync;
   logic [1:0] r_sda_sync;
   logic       r_scl_d;
   logic       r_sda_d;
   logic       w_scl;
   logic       w_sda;

   // Idle bus is high; resetting to 1 keeps reset release from looking like an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
      end else begin
         r_scl_sync <= {r_scl_sync[0], i_scl};
         r_sda_sync <= {r_sda_sync[0], i_sda};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   import i2c_target_pkg::maj3;

   logic [1:0] r_scl_hist;
   logic [1:0] r_sda_hist;
   logic       r_scl_filt;
   logic       r_sda_filt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_hist <= 2'b11;
         r_sda_hist <= 2'b11;
         r_scl_filt <= 1'b1;
         r_sda_filt <= 1'b1;
      end else begin
         r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
         r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
         r_scl_filt <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
         r_sda_filt <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
      end
   end

   assign w_scl = r_scl_filt;
   assign w_sda = r_sda_filt;
`else
   assign w_scl = r_scl_sync[1];
   assign w_sda = r_sda_sync[1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_d <= 1'b1;
         r_sda_d <= 1'b1;
      end else begin
         r_scl_d <= w_scl;
         r_sda_d <= w_sda;
      end
   end

   // SCL must be high on both samples so an SDA move right at an SCL edge is not a condition.
   assign o_sda      = w_sda;
   assign o_scl_rise = w_scl & ~r_scl_d;
   assign o_scl_fall = ~w_scl & r_scl_d;
   assign o_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
   assign o_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-addressed register file and auto-incrementing pointer; never stretches SCL.
// SDA moves 1 clk after a detected SCL fall; wr_valid/regs update 1 clk after the 8th-bit SCL rise.
module i2c_target_regs
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         DEPTH       = 16,
   parameter int         AW          = $clog2(DEPTH)
) (
   input logic              clk,
   input logic              rst,
   i2c_target_regs_if.slave bus
);
   i2c_target_state_e r_state;
   logic [2:0]        r_bitcnt;
   logic [7:0]        r_shift;
   logic [AW-1:0]     r_ptr;
   logic              r_rw;
   logic              r_ack_ph;
   logic              r_mack;
   logic              r_sda_o;
   logic              r_busy;
   logic              r_wr_valid;
   logic [AW-1:0]     r_wr_addr;
   logic [7:0]        r_wr_data;
   logic [7:0]        r_regs [DEPTH];

   logic              w_sda;
   logic              w_scl_rise;
   logic              w_scl_fall;
   logic              w_start;
   logic              w_stop;
   logic [7:0]        w_byte;
   logic              w_last_bit;
   logic [AW-1:0]     w_ptr_nxt;

   i2c_line_cond u_line_cond (
      .clk        (clk),
      .rst        (rst),
      .i_scl      (bus.i2c_scl_i),
      .i_sda      (bus.i2c_sda_i),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   assign w_byte     = {r_shift[6:0], w_sda};
   assign w_last_bit = (r_bitcnt == 3'd7);
   assign w_ptr_nxt  = r_ptr + 1'b1;

   // ACK states see two SCL falls: the first opens the ACK slot, the second closes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_ptr      <= '0;
         r_rw       <= I2C_RW_WRITE;
         r_ack_ph   <= 1'b0;
         r_mack     <= I2C_NACK;
         r_sda_o    <= 1'b1;
         r_busy     <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      end else begin
         r_wr_valid <= 1'b0;
         if (w_stop) begin
            r_state <= ST_IDLE;
            r_sda_o <= 1'b1;
            r_busy  <= 1'b0;
         end else if (w_start) begin
            r_state  <= ST_ADDR;
            r_bitcnt <= '0;
            r_sda_o  <= 1'b1;
         end else begin
            case (r_state)
               ST_ADDR: begin
                  if (w_scl_rise) begin
                     r_shift  <= w_byte;
                     r_bitcnt <= r_bitcnt + 1'b1;
                     if (w_last_bit) begin
                        if (w_byte[7:1] == TARGET_ADDR) begin
                           r_state  <= ST_ADDR_ACK;
                           r_rw     <= w_byte[0];
                           r_ack_ph <= 1'b0;
                           r_busy   <= 1'b1;
                        end else begin
                           r_state <= ST_IGNORE;
                        end
                     end
                  end
               end

               ST_ADDR_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_ack_ph) begin
                        r_sda_o  <= I2C_ACK;
                        r_ack_ph <= 1'b1;
                     end else begin
                        r_bitcnt <= '0;
                        if (r_rw == I2C_RW_READ) begin
                           r_state <= ST_RDATA;
                           r_shift <= r_regs[r_ptr];
                           r_sda_o <= r_regs[r_ptr][7];
                        end else begin
                           r_state <= ST_PTR;
                           r_sda_o <= 1'b1;
                        end
                     end
                  end
               end

               ST_PTR: begin
                  if (w_scl_rise) begin
                     r_shift  <= w_byte;
                     r_bitcnt <= r_bitcnt + 1'b1;
                     if (w_last_bit) begin
                        r_ptr    <= w_byte[AW-1:0];
                        r_state  <= ST_PTR_ACK;
                        r_ack_ph <= 1'b0;
                     end
                  end
               end

               ST_WDATA: begin
                  if (w_scl_rise) begin
                     r_shift  <= w_byte;
                     r_bitcnt <= r_bitcnt + 1'b1;
                     if (w_last_bit) begin
                        r_regs[r_ptr] <= w_byte;
                        r_wr_valid    <= 1'b1;
                        r_wr_addr     <= r_ptr;
                        r_wr_data     <= w_byte;
                        r_ptr         <= w_ptr_nxt;
                        r_state       <= ST_WDATA_ACK;
                        r_ack_ph      <= 1'b0;
                     end
                  end
               end

               ST_PTR_ACK, ST_WDATA_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_ack_ph) begin
                        r_sda_o  <= I2C_ACK;
                        r_ack_ph <= 1'b1;
                     end else begin
                        r_sda_o  <= 1'b1;
                        r_bitcnt <= '0;
                        r_state  <= ST_WDATA;
                     end
                  end
               end

               ST_RDATA: begin
                  if (w_scl_rise) begin
                     r_bitcnt <= r_bitcnt + 1'b1;
                     if (w_last_bit) begin
                        r_state  <= ST_RDATA_ACK;
                        r_ack_ph <= 1'b0;
                     end
                  end else if (w_scl_fall) begin
                     r_shift <= {r_shift[6:0], 1'b0};
                     r_sda_o <= r_shift[6];
                  end
               end

               ST_RDATA_ACK: begin
                  if (w_scl_rise) begin
                     r_mack <= w_sda;
                  end else if (w_scl_fall) begin
                     if (!r_ack_ph) begin
                        r_sda_o  <= 1'b1;
                        r_ack_ph <= 1'b1;
                     end else if (r_mack == I2C_ACK) begin
                        r_ptr    <= w_ptr_nxt;
                        r_shift  <= r_regs[w_ptr_nxt];
                        r_sda_o  <= r_regs[w_ptr_nxt][7];
                        r_bitcnt <= '0;
                        r_state  <= ST_RDATA;
                     end else begin
                        r_sda_o <= 1'b1;
                        r_state <= ST_IGNORE;
                     end
                  end
               end

               ST_IDLE, ST_IGNORE: begin
                  r_sda_o <= 1'b1;
               end

               default: begin
                  r_state <= ST_IDLE;
                  r_sda_o <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.i2c_sda_o   = r_sda_o;
   assign bus.i2c_sda_t   = r_sda_o;
   assign bus.reg_rd_data = r_regs[bus.reg_rd_addr];
   assign bus.wr_valid    = r_wr_valid;
   assign bus.wr_addr     = r_wr_addr;
   assign bus.wr_data     = r_wr_data;
   assign bus.busy        = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed plus randomized I2C transactions against a register-array model; the glitch case
// is exercised only when I2C_TARGET_GLITCH_FILTER_EN is defined.
module tb_i2c_target_regs;
   localparam int         DEPTH = 16;
   localparam int         AW    = 4;
   localparam int         QC    = 7;
   localparam logic [6:0] TADDR = 7'h50;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic m_scl = 1'b1;
   logic m_sda = 1'b1;
   logic [AW-1:0] peek_addr = '0;

   always #5 clk = ~clk;

   i2c_target_regs_if #(.AW(AW)) bus_if ();
   assign bus_if.i2c_scl_i   = m_scl;
   assign bus_if.i2c_sda_i   = m_sda & bus_if.i2c_sda_o;
   assign bus_if.reg_rd_addr = peek_addr;

   i2c_target_regs #(.TARGET_ADDR(TADDR), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mdl_regs [DEPTH];
   int         mdl_ptr = 0;
   logic [7:0] stg [$];

   // Bus observer: write events, SDA pulls, busy cycles, pulse width and sda_t tracking.
   int            n_wr = 0, n_sda_low = 0, n_busy = 0, n_wr_long = 0, n_t_mis = 0;
   logic [AW-1:0] obs_addr [256];
   logic [7:0]    obs_data [256];
   logic          prev_wv = 1'b0;

   always @(negedge clk) begin
      if (bus_if.wr_valid === 1'b1) begin
         if (n_wr < 256) begin
            obs_addr[n_wr] = bus_if.wr_addr;
            obs_data[n_wr] = bus_if.wr_data;
         end
         n_wr++;
         if (prev_wv) n_wr_long++;
      end
      prev_wv = (bus_if.wr_valid === 1'b1);
      if (bus_if.i2c_sda_o !== 1'b1) n_sda_low++;
      if (bus_if.busy !== 1'b0) n_busy++;
      if (bus_if.i2c_sda_t !== bus_if.i2c_sda_o) n_t_mis++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic q();
      repeat (QC) @(negedge clk);
   endtask

   task automatic clk_bit(input logic b, input bit glitch, output logic s);
      m_sda = b;
      q();
      m_scl = 1'b1;
      q();
      s = bus_if.i2c_sda_i;
      if (glitch) begin
         m_sda = 1'b0;
         @(negedge clk);
         m_sda = b;
      end
      q();
      m_scl = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic i2c_start();
      if (!m_scl) begin
         m_sda = 1'b1;
         q();
         m_scl = 1'b1;
         q();
      end
      m_sda = 1'b0;
      q();
      m_scl = 1'b0;
      q();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      q();
      m_scl = 1'b1;
      q();
      m_sda = 1'b1;
      q();
      q();
   endtask

   task automatic wr_byte(input logic [7:0] b, input bit glitch, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], glitch && (i == 0), s);
      clk_bit(1'b1, 1'b0, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, 1'b0, s);
         d[i] = s;
      end
      clk_bit(nack, 1'b0, s);
   endtask

   task automatic peek(input int a, input logic [7:0] exp, input string tag);
      peek_addr = AW'(a);
      #1;
      chk(tag, bus_if.reg_rd_data, exp);
   endtask

   // Write address, pointer, then every byte in stg; glitch hits the first data byte's LSB.
   task automatic do_write(input logic [7:0] ptr_b, input bit glitch, input string tag);
      logic ack;
      int   w0, p0;
      w0 = n_wr;
      p0 = int'(ptr_b) % DEPTH;
      i2c_start();
      wr_byte({TADDR, 1'b0}, 1'b0, ack);
      chk({tag, " addr ack"}, ack, 0);
      chk({tag, " busy"}, bus_if.busy, 1);
      wr_byte(ptr_b, 1'b0, ack);
      chk({tag, " ptr ack"}, ack, 0);
      mdl_ptr = p0;
      foreach (stg[i]) begin
         wr_byte(stg[i], glitch && (i == 0), ack);
         chk({tag, " data ack"}, ack, 0);
         mdl_regs[mdl_ptr] = stg[i];
         mdl_ptr = (mdl_ptr + 1) % DEPTH;
      end
      i2c_stop();
      chk({tag, " busy after stop"}, bus_if.busy, 0);
      chk({tag, " wr count"}, n_wr - w0, stg.size());
      foreach (stg[i]) begin
         chk({tag, " wr_addr"}, obs_addr[w0 + i], (p0 + i) % DEPTH);
         chk({tag, " wr_data"}, obs_data[w0 + i], stg[i]);
         peek((p0 + i) % DEPTH, mdl_regs[(p0 + i) % DEPTH], {tag, " peek"});
      end
   endtask

   // Optional pointer set, then a repeated-start (or fresh) read of n bytes, NACK on the last.
   task automatic do_read(input logic [7:0] ptr_b, input int n, input bit set_ptr, input string tag);
      logic       ack;
      logic [7:0] d;
      int         p;
      i2c_start();
      if (set_ptr) begin
         wr_byte({TADDR, 1'b0}, 1'b0, ack);
         chk({tag, " addr ack"}, ack, 0);
         wr_byte(ptr_b, 1'b0, ack);
         chk({tag, " ptr ack"}, ack, 0);
         mdl_ptr = int'(ptr_b) % DEPTH;
         i2c_start();
      end
      wr_byte({TADDR, 1'b1}, 1'b0, ack);
      chk({tag, " rd addr ack"}, ack, 0);
      p = mdl_ptr;
      for (int i = 0; i < n; i++) begin
         rd_byte(i == n - 1, d);
         chk({tag, " data"}, d, mdl_regs[(p + i) % DEPTH]);
      end
      mdl_ptr = (p + n - 1) % DEPTH;
      repeat (4) @(negedge clk);
      chk({tag, " sda released after nack"}, bus_if.i2c_sda_o, 1);
      i2c_stop();
   endtask

   initial begin
      logic ack;
      int   s0, b0, w0, k, rp, rn;

      for (int i = 0; i < DEPTH; i++) mdl_regs[i] = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      chk("reset sda_o", bus_if.i2c_sda_o, 1);
      chk("reset sda_t", bus_if.i2c_sda_t, 1);
      chk("reset wr_valid", bus_if.wr_valid, 0);
      chk("reset wr_addr", bus_if.wr_addr, 0);
      chk("reset wr_data", bus_if.wr_data, 0);
      chk("reset busy", bus_if.busy, 0);
      for (int i = 0; i < DEPTH; i++) peek(i, 8'h00, "reset regs");

      // Write burst from pointer 3.
      stg.delete();
      stg.push_back(8'h11);
      stg.push_back(8'h22);
      do_write(8'h03, 1'b0, "burst");
      peek(4, 8'h22, "burst regs[4]");

      // Pointer-only write then repeated-start read of two bytes.
      do_read(8'h04, 2, 1'b1, "randrd");

      // Foreign address: no ACK, no drive, no busy, no writes.
      s0 = n_sda_low;
      b0 = n_busy;
      w0 = n_wr;
      i2c_start();
      wr_byte(8'hA2, 1'b0, ack);
      chk("wrongaddr addr nack", ack, 1);
      wr_byte(8'h05, 1'b0, ack);
      chk("wrongaddr ptr nack", ack, 1);
      wr_byte(8'h77, 1'b0, ack);
      chk("wrongaddr data nack", ack, 1);
      i2c_stop();
      chk("wrongaddr sda pulls", n_sda_low - s0, 0);
      chk("wrongaddr busy cycles", n_busy - b0, 0);
      chk("wrongaddr writes", n_wr - w0, 0);

      // Pointer wrap at the top of the register file.
      stg.delete();
      stg.push_back(8'hAA);
      stg.push_back(8'hBB);
      do_write(8'h0F, 1'b0, "wrap");
      peek(15, 8'hAA, "wrap regs[15]");
      peek(0, 8'hBB, "wrap regs[0]");

      // Randomized bursts, pointer reads and current-address reads.
      for (int it = 0; it < 6; it++) begin
         stg.delete();
         rp = int'($urandom_range(0, 255));
         rn = int'($urandom_range(1, 4));
         for (int j = 0; j < rn; j++) stg.push_back(8'($urandom));
         do_write(8'(rp), 1'b0, "rnd wr");
         do_read(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)), 1'b1, "rnd rd");
         do_read(8'h00, int'($urandom_range(1, 2)), 1'b0, "rnd cur");
      end

      // Reset while the target drives a 0 data bit.
      stg.delete();
      stg.push_back(8'h00);
      do_write(8'h09, 1'b0, "pre-rst");
      i2c_start();
      wr_byte({TADDR, 1'b0}, 1'b0, ack);
      wr_byte(8'h09, 1'b0, ack);
      i2c_start();
      wr_byte({TADDR, 1'b1}, 1'b0, ack);
      chk("midrst rd addr ack", ack, 0);
      k = 0;
      while (bus_if.i2c_sda_o !== 1'b0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("midrst target driving 0", bus_if.i2c_sda_o, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst sda_o released", bus_if.i2c_sda_o, 1);
      chk("midrst sda_t released", bus_if.i2c_sda_t, 1);
      m_sda = 1'b1;
      @(negedge clk);
      m_scl = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) mdl_regs[i] = 8'h00;
      mdl_ptr = 0;
      repeat (3) @(negedge clk);
      chk("midrst busy", bus_if.busy, 0);
      for (int i = 0; i < DEPTH; i++) peek(i, 8'h00, "midrst regs");
      stg.delete();
      stg.push_back(8'h5A);
      stg.push_back(8'hC3);
      do_write(8'h02, 1'b0, "postrst");
      do_read(8'h02, 2, 1'b1, "postrst rd");

`ifdef I2C_TARGET_GLITCH_FILTER_EN
      // One-clk SDA low pulse while SCL is high must not look like START/STOP.
      stg.delete();
      stg.push_back(8'h35);
      stg.push_back(8'h81);
      do_write(8'h07, 1'b1, "glitch");
      do_read(8'h07, 2, 1'b1, "glitch rd");
`endif

      chk("wr_valid single-cycle", n_wr_long, 0);
      chk("sda_t tracks sda_o", n_t_mis, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
